fir_coeff_loader: RTL

Loads a full set of FIR coefficients into the filter's coefficient memory from a byte stream, such as a UART receiver output. It writes into the write port of the same 512×16 coefficient memory that `fir_filter` reads, and it tells the filter when the table is complete and verified. It parses a framed stream (sync byte, 1024 data bytes, checksum), generates write strobes, and flags success, checksum failure or inter-byte timeout.

---
 rtl/fir_pkg.sv | 17 +
 rtl/coeff_gap_timer.sv | 41 ++++
 rtl/fir_coeff_loader.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// Shared definitions for the FIR filter and its coefficient loader.
// Holds the coefficient memory geometry, the loader frame sync byte and
// the loader state encoding.
package fir_pkg;

  localparam int unsigned COEFF_ADDR_WIDTH = 9;
  localparam int unsigned COEFF_DATA_WIDTH = 16;
  localparam logic [7:0]  COEFF_SYNC_BYTE  = 8'hA5;

  typedef enum logic [1:0] {
    StIdle,
    StLo,
    StHi,
    StCsum
  } loader_state_e;

endpackage

// File: rtl/coeff_gap_timer.sv
// Inter-byte gap timer for the coefficient loader.
// Ports:
//   clk, nreset : clock, asynchronous active-low reset
//   clear       : a byte was accepted this cycle; restart the gap count
//   run         : a frame is in progress; count idle cycles
//   expired     : single-cycle terminal-count pulse (combinational)
module coeff_gap_timer #(
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic clk,
  input  logic nreset,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // An accepted byte in the terminal-count cycle wins over the timeout.
  assign expired = run && !clear && (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clear || !run || expired) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// Loads the FIR coefficient table from a framed byte stream:
// sync byte, 2 bytes per word (low first) for every table entry, checksum.
// Ports:
//   clk, nreset          : clock, asynchronous active-low reset
//   rx_valid/rx_data     : incoming byte stream
//   rx_ready             : loader accepts bytes (high whenever out of reset)
//   coeff_we/addr/data   : registered write port to the coefficient memory
//   busy                 : a frame is in progress
//   coeff_valid          : table holds a complete, verified set
//   load_ok / load_err   : one-cycle result pulses
module fir_coeff_loader
  import fir_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = COEFF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = COEFF_DATA_WIDTH,
  parameter logic [7:0]  SYNC_BYTE  = COEFF_SYNC_BYTE,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  output logic                  coeff_we,
  output logic [ADDR_WIDTH-1:0] coeff_addr,
  output logic [DATA_WIDTH-1:0] coeff_data,
  output logic                  busy,
  output logic                  coeff_valid,
  output logic                  load_ok,
  output logic                  load_err
);

  loader_state_e         state_q, state_d;
  logic [7:0]            lo_q, lo_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  we_q, we_d;
  logic                  valid_q, valid_d;
  logic                  ok_q, ok_d;
  logic                  err_q, err_d;
  logic                  rdy_q;
  logic                  accept;
  logic                  expired;
  logic [7:0]            csum_next;

  assign accept    = rx_valid && rdy_q;
  assign csum_next = csum_q + rx_data;

  coeff_gap_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_gap_timer (
    .clk     (clk),
    .nreset  (nreset),
    .clear   (accept),
    .run     (busy),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    csum_d  = csum_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    we_d    = 1'b0;
    ok_d    = 1'b0;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_d = StLo;
          idx_d   = '0;
          csum_d  = '0;
          valid_d = 1'b0;
        end
      end
      StLo: begin
        if (accept) begin
          lo_d    = rx_data;
          csum_d  = csum_next;
          state_d = StHi;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StHi: begin
        if (accept) begin
          we_d    = 1'b1;
          addr_d  = idx_q;
          data_d  = DATA_WIDTH'({rx_data, lo_q});
          csum_d  = csum_next;
          // Index wraps to 0 after the last entry.
          idx_d   = idx_q + ADDR_WIDTH'(1);
          state_d = (&idx_q) ? StCsum : StLo;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      StCsum: begin
        if (accept) begin
          csum_d  = csum_next;
          ok_d    = (csum_next == 8'h00);
          err_d   = (csum_next != 8'h00);
          valid_d = (csum_next == 8'h00);
          state_d = StIdle;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= StIdle;
      lo_q    <= '0;
      csum_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      valid_q <= 1'b0;
      ok_q    <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      csum_q  <= csum_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      valid_q <= valid_d;
      ok_q    <= ok_d;
      err_q   <= err_d;
      rdy_q   <= 1'b1;
    end
  end

  assign rx_ready    = rdy_q;
  assign coeff_we    = we_q;
  assign coeff_addr  = addr_q;
  assign coeff_data  = data_q;
  assign busy        = (state_q != StIdle);
  assign coeff_valid = valid_q;
  assign load_ok     = ok_q;
  assign load_err    = err_q;

endmodule
